s2_regfile_stage: RTL and testbench

S2_REGFILE_STAGE -- requirements
Module: s2_regfile_stage

---
 rtl/s2_regfile_stage_pkg.sv | 20 ++
 rtl/regfile_2r1w.sv | 51 +++++
 rtl/s2_regfile_stage.sv | 84 ++++++++
 tb/tb_s2_regfile_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/s2_regfile_stage_pkg.sv
// Shared pipeline constants and types used by the stage registers.
// Latency: n/a (declarations only).
// Backpressure: n/a; the pipeline has no stall or flush.
package s2_regfile_stage_pkg;

  localparam int PL_DATA_WIDTH = 32;  // default datapath / register width
  localparam int PL_NUM_REGS   = 32;  // default register-file depth
  localparam int REG_ADDR_W    = 5;   // register select width
  localparam int ALU_OP_W      = 3;   // ALU opcode width
  localparam int IMM_W         = 16;  // raw immediate width

  // Control fields forwarded unchanged from stage 1 into stage 2.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] write_sel;
    logic                  data_source;
    logic                  write_en;
    logic [ALU_OP_W-1:0]   alu_op;
  } ctrl_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two combinational read ports, one clocked write port, r0 hard-wired to zero.
// Latency: reads are combinational (0 cycles); writes land on the rising edge.
// Backpressure: none; a write is accepted every cycle it is requested.
// Ports: clk/rst; rsel1_i/rsel2_i read selects -> rdata1_o/rdata2_o;
//        wsel_i/wdata_i/we_i write port, also bypassed onto matching read ports.
module regfile_2r1w
  import s2_regfile_stage_pkg::*;
#(
  parameter int DATA_WIDTH = PL_DATA_WIDTH,
  parameter int NUM_REGS   = PL_NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rsel1_i,
  input  logic [REG_ADDR_W-1:0] rsel2_i,
  input  logic [REG_ADDR_W-1:0] wsel_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  we_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [DATA_WIDTH-1:0] rdata2_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic                  wr_ok;

  // A write to r0 (or past the end of the file) is neither stored nor bypassed.
  assign wr_ok = we_i && (wsel_i != '0) && (32'(wsel_i) < NUM_REGS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wsel_i] <= wdata_i;
    end
  end

  // Bypass wins over the stored entry so the consumer never sees stale data
  // for a register being written in the same cycle.
  always_comb begin
    rdata1_o = '0;
    if (rsel1_i != '0 && 32'(rsel1_i) < NUM_REGS) rdata1_o = mem_q[rsel1_i];
    if (wr_ok && wsel_i == rsel1_i)                rdata1_o = wdata_i;
  end

  always_comb begin
    rdata2_o = '0;
    if (rsel2_i != '0 && 32'(rsel2_i) < NUM_REGS) rdata2_o = mem_q[rsel2_i];
    if (wr_ok && wsel_i == rsel2_i)                rdata2_o = wdata_i;
  end

endmodule

// File: rtl/s2_regfile_stage.sv
// Pipeline stage 2: register-file read, immediate sign extension, control forwarding.
// Latency: 1 cycle from stage-1 inputs to _S2 outputs.
// Backpressure: none; the stage advances every cycle out of reset.
// Ports: clk/rst; ReadSelect1/2, WriteSelect_S1, Immediate_S1, DataSource_S1,
//        WriteEnable_S1, AluOp_S1 from stage 1; WriteSelect_WB/WriteData_WB/WriteEnable_WB
//        writeback; registered ReadData1/2_S2, Immediate_S2 and forwarded control _S2.
module s2_regfile_stage
  import s2_regfile_stage_pkg::*;
#(
  parameter int DATA_WIDTH = PL_DATA_WIDTH,
  parameter int NUM_REGS   = PL_NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ReadSelect1,
  input  logic [REG_ADDR_W-1:0] ReadSelect2,
  input  logic [REG_ADDR_W-1:0] WriteSelect_S1,
  input  logic [IMM_W-1:0]      Immediate_S1,
  input  logic                  DataSource_S1,
  input  logic                  WriteEnable_S1,
  input  logic [ALU_OP_W-1:0]   AluOp_S1,
  input  logic [REG_ADDR_W-1:0] WriteSelect_WB,
  input  logic [DATA_WIDTH-1:0] WriteData_WB,
  input  logic                  WriteEnable_WB,
  output logic [DATA_WIDTH-1:0] ReadData1_S2,
  output logic [DATA_WIDTH-1:0] ReadData2_S2,
  output logic [DATA_WIDTH-1:0] Immediate_S2,
  output logic [REG_ADDR_W-1:0] WriteSelect_S2,
  output logic                  DataSource_S2,
  output logic                  WriteEnable_S2,
  output logic [ALU_OP_W-1:0]   AluOp_S2
);

  logic [DATA_WIDTH-1:0] rd1_d, rd2_d, imm_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd2_q, imm_q;
  ctrl_t                 ctrl_d, ctrl_q;

  regfile_2r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .rsel1_i  (ReadSelect1),
    .rsel2_i  (ReadSelect2),
    .wsel_i   (WriteSelect_WB),
    .wdata_i  (WriteData_WB),
    .we_i     (WriteEnable_WB),
    .rdata1_o (rd1_d),
    .rdata2_o (rd2_d)
  );

  always_comb begin
    imm_d              = {{(DATA_WIDTH-IMM_W){Immediate_S1[IMM_W-1]}}, Immediate_S1};
    ctrl_d             = '0;
    ctrl_d.write_sel   = WriteSelect_S1;
    ctrl_d.data_source = DataSource_S1;
    ctrl_d.write_en    = WriteEnable_S1;
    ctrl_d.alu_op      = AluOp_S1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      ctrl_q <= '0;
    end else begin
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign ReadData1_S2   = rd1_q;
  assign ReadData2_S2   = rd2_q;
  assign Immediate_S2   = imm_q;
  assign WriteSelect_S2 = ctrl_q.write_sel;
  assign DataSource_S2  = ctrl_q.data_source;
  assign WriteEnable_S2 = ctrl_q.write_en;
  assign AluOp_S2       = ctrl_q.alu_op;

endmodule

// File: tb/tb_s2_regfile_stage.sv
// Self-checking bench for s2_regfile_stage: directed cases plus randomized traffic
// compared against a behavioural register-file model.
module tb_s2_regfile_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, ws_s1, ws_wb;
  logic [15:0] imm;
  logic        ds, we_s1, we_wb;
  logic [2:0]  aop;
  logic [31:0] wd_wb;

  logic [31:0] rd1_o, rd2_o, imm_o;
  logic [4:0]  ws_o;
  logic        ds_o, we_o;
  logic [2:0]  aop_o;

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] model_rf [32];

  always #5 clk = ~clk;

  s2_regfile_stage #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ReadSelect1    (rs1),
    .ReadSelect2    (rs2),
    .WriteSelect_S1 (ws_s1),
    .Immediate_S1   (imm),
    .DataSource_S1  (ds),
    .WriteEnable_S1 (we_s1),
    .AluOp_S1       (aop),
    .WriteSelect_WB (ws_wb),
    .WriteData_WB   (wd_wb),
    .WriteEnable_WB (we_wb),
    .ReadData1_S2   (rd1_o),
    .ReadData2_S2   (rd2_o),
    .Immediate_S2   (imm_o),
    .WriteSelect_S2 (ws_o),
    .DataSource_S2  (ds_o),
    .WriteEnable_S2 (we_o),
    .AluOp_S2       (aop_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Value a consumer should see: r0 is zero, a same-cycle write is visible, else stored value.
  function automatic logic [31:0] model_read(input logic [4:0] sel);
    if (sel == 5'd0) return 32'd0;
    if (we_wb && ws_wb == sel) return wd_wb;
    return model_rf[sel];
  endfunction

  // Two's-complement value of the 16-bit immediate, expressed as a 32-bit pattern.
  function automatic logic [31:0] model_sext(input logic [15:0] v);
    if (v >= 16'h8000) return 32'(v) - 32'h0001_0000;
    return 32'(v);
  endfunction

  task automatic set_idle();
    rs1 = 0; rs2 = 0; ws_s1 = 0; imm = 0; ds = 0; we_s1 = 0; aop = 0;
    ws_wb = 0; wd_wb = 0; we_wb = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, " rd1"}, rd1_o, 32'd0);
    check_val({tag, " rd2"}, rd2_o, 32'd0);
    check_val({tag, " imm"}, imm_o, 32'd0);
    check_val({tag, " ws"},  32'(ws_o), 32'd0);
    check_val({tag, " ds"},  32'(ds_o), 32'd0);
    check_val({tag, " we"},  32'(we_o), 32'd0);
    check_val({tag, " aop"}, 32'(aop_o), 32'd0);
  endtask

  // Apply current inputs across one rising edge (rst low) and compare every output.
  task automatic cycle_check(input string tag);
    logic [31:0] e1, e2, ei;
    logic [4:0]  ews;
    logic        eds, ewe;
    logic [2:0]  eaop;
    e1 = model_read(rs1);
    e2 = model_read(rs2);
    ei = model_sext(imm);
    ews = ws_s1; eds = ds; ewe = we_s1; eaop = aop;
    @(posedge clk);
    if (we_wb && ws_wb != 5'd0) model_rf[ws_wb] = wd_wb;
    #1;
    check_val({tag, " rd1"}, rd1_o, e1);
    check_val({tag, " rd2"}, rd2_o, e2);
    check_val({tag, " imm"}, imm_o, ei);
    check_val({tag, " ws"},  32'(ws_o), 32'(ews));
    check_val({tag, " ds"},  32'(ds_o), 32'(eds));
    check_val({tag, " we"},  32'(we_o), 32'(ewe));
    check_val({tag, " aop"}, 32'(aop_o), 32'(eaop));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    set_idle();
    rst = 1'b1;
    #3;
    check_all_zero("reset_init");
    @(posedge clk); #1;
    rst = 1'b0;

    // Write r3, then read it back through port 1.
    ws_wb = 5'd3; wd_wb = 32'hDEADBEEF; we_wb = 1'b1;
    cycle_check("wr_r3");
    set_idle(); rs1 = 5'd3;
    cycle_check("rd_r3");
    check_val("write_then_read r3", rd1_o, 32'hDEADBEEF);

    // Same-cycle bypass onto both ports.
    set_idle(); ws_wb = 5'd7; wd_wb = 32'h12345678; we_wb = 1'b1; rs1 = 5'd7; rs2 = 5'd7;
    cycle_check("bypass_r7");
    check_val("bypass port1", rd1_o, 32'h12345678);
    check_val("bypass port2", rd2_o, 32'h12345678);

    // r0 stays zero, in the writing cycle and after.
    set_idle(); ws_wb = 5'd0; wd_wb = 32'hFFFFFFFF; we_wb = 1'b1; rs2 = 5'd0;
    cycle_check("r0_same");
    check_val("r0 same cycle", rd2_o, 32'd0);
    set_idle(); rs2 = 5'd0; rs1 = 5'd0;
    cycle_check("r0_later");
    check_val("r0 later cycle", rd2_o, 32'd0);

    // Sign extension.
    set_idle(); imm = 16'h8001;
    cycle_check("imm_neg");
    check_val("sext 8001", imm_o, 32'hFFFF8001);
    imm = 16'h7FFF;
    cycle_check("imm_pos");
    check_val("sext 7fff", imm_o, 32'h00007FFF);

    // Control passthrough, exactly one edge later.
    set_idle(); aop = 3'b101; ds = 1'b1; ws_s1 = 5'd9; we_s1 = 1'b1;
    cycle_check("ctrl");
    check_val("ctrl aluop", 32'(aop_o), 32'd5);
    check_val("ctrl dsrc",  32'(ds_o), 32'd1);
    check_val("ctrl wsel",  32'(ws_o), 32'd9);
    check_val("ctrl wen",   32'(we_o), 32'd1);

    // Randomized traffic; writeback select often aliases a read select.
    for (int n = 0; n < 300; n++) begin
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      ws_s1 = 5'($urandom); imm = 16'($urandom); ds = 1'($urandom);
      we_s1 = 1'($urandom); aop = 3'($urandom);
      we_wb = 1'($urandom);
      wd_wb = $urandom;
      case ($urandom_range(0, 3))
        0: ws_wb = rs1;
        1: ws_wb = rs2;
        default: ws_wb = 5'($urandom_range(0, 31));
      endcase
      cycle_check("rand");
    end

    // Mid-run reset: make r5 nonzero, then pulse rst between edges.
    set_idle(); ws_wb = 5'd5; wd_wb = 32'hA5A5A5A5; we_wb = 1'b1;
    imm = 16'hFFFF; aop = 3'd7; ds = 1'b1; we_s1 = 1'b1; ws_s1 = 5'd31; rs1 = 5'd3;
    cycle_check("pre_rst");
    #2;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    #1;
    check_all_zero("async_rst");
    // A writeback presented while reset is held must be lost.
    set_idle(); ws_wb = 5'd6; wd_wb = 32'h0BADF00D; we_wb = 1'b1;
    @(posedge clk); #1;
    check_all_zero("held_rst");
    rst = 1'b0;
    set_idle(); rs1 = 5'd5; rs2 = 5'd6;
    cycle_check("post_rst");
    check_val("r5 after reset", rd1_o, 32'd0);
    check_val("r6 write during reset", rd2_o, 32'd0);

    // Normal operation resumes after reset.
    set_idle(); ws_wb = 5'd5; wd_wb = 32'h00C0FFEE; we_wb = 1'b1;
    cycle_check("resume_wr");
    set_idle(); rs1 = 5'd5;
    cycle_check("resume_rd");
    check_val("resume r5", rd1_o, 32'h00C0FFEE);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
